// File: rtl/dmi_pkg.sv
// Shared DMI encodings: op/resp codes, register map and responder FSM states.
package dmi_pkg;

  typedef enum logic [1:0] {
    DmiNop   = 2'd0,
    DmiRead  = 2'd1,
    DmiWrite = 2'd2,
    DmiRsvd  = 2'd3
  } dmi_op_e;

  localparam logic [1:0] DmiRespSuccess = 2'd0;
  localparam logic [1:0] DmiRespFailed  = 2'd2;

  localparam logic [6:0] AddrData0     = 7'h04;
  localparam logic [6:0] AddrDmcontrol = 7'h10;
  localparam logic [6:0] AddrDmstatus  = 7'h11;

  // version=2, authenticated=1
  localparam logic [31:0] DMSTATUS_VALUE = 32'h0000_0082;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dmi_state_e;

  // data0..data3 occupy one aligned block of four addresses
  function automatic logic is_data_addr(logic [6:0] addr);
    return addr[6:2] == AddrData0[6:2];
  endfunction

endpackage

// File: rtl/dmi_responder.sv
// Minimal DMI target: data0..3 scratch, dmcontrol (haltreq/ndmreset/dmactive), dmstatus,
// with a programmable access latency between request acceptance and response.
module dmi_responder
  import dmi_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        debug_req_valid,
  output logic        debug_req_ready,
  input  logic [6:0]  debug_req_bits_addr,
  input  logic [1:0]  debug_req_bits_op,
  input  logic [31:0] debug_req_bits_data,
  output logic        debug_resp_valid,
  input  logic        debug_resp_ready,
  output logic [1:0]  debug_resp_bits_resp,
  output logic [31:0] debug_resp_bits_data,
  output logic        dmactive,
  output logic        ndmreset,
  output logic        haltreq
);

  localparam logic [3:0] WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmi_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [6:0]        addr_q, addr_d;
  dmi_op_e           op_q, op_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        resp_q, resp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [3:0][31:0]  data_q, data_d;
  logic              dmactive_q, dmactive_d;
  logic              ndmreset_q, ndmreset_d;
  logic              haltreq_q, haltreq_d;

  logic              access;
  logic [6:0]        sel_addr;
  dmi_op_e           sel_op;
  logic [31:0]       sel_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (debug_req_valid) begin
          addr_d  = debug_req_bits_addr;
          op_d    = dmi_op_e'(debug_req_bits_op);
          wdata_d = debug_req_bits_data;
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
            access  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (debug_resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // With zero wait the access happens on the accept edge, before the capture flops load.
  always_comb begin
    sel_addr = (state_q == StIdle) ? debug_req_bits_addr : addr_q;
    sel_op   = (state_q == StIdle) ? dmi_op_e'(debug_req_bits_op) : op_q;
    sel_data = (state_q == StIdle) ? debug_req_bits_data : wdata_q;
  end

  always_comb begin
    resp_d     = resp_q;
    rdata_d    = rdata_q;
    data_d     = data_q;
    dmactive_d = dmactive_q;
    ndmreset_d = ndmreset_q;
    haltreq_d  = haltreq_q;
    if (access) begin
      resp_d  = DmiRespSuccess;
      rdata_d = '0;
      unique case (sel_op)
        DmiNop: ;
        DmiRead: begin
          if (is_data_addr(sel_addr)) begin
            rdata_d = data_q[sel_addr[1:0]];
          end else if (sel_addr == AddrDmcontrol) begin
            rdata_d = {haltreq_q, 29'd0, ndmreset_q, dmactive_q};
          end else if (sel_addr == AddrDmstatus) begin
            rdata_d = DMSTATUS_VALUE;
          end
        end
        DmiWrite: begin
          if (is_data_addr(sel_addr)) begin
            data_d[sel_addr[1:0]] = sel_data;
          end else if (sel_addr == AddrDmcontrol) begin
            if (sel_data[0]) begin
              dmactive_d = 1'b1;
              ndmreset_d = sel_data[1];
              haltreq_d  = sel_data[31];
            end else begin
              // Dropping dmactive resets the whole debug module state.
              dmactive_d = 1'b0;
              ndmreset_d = 1'b0;
              haltreq_d  = 1'b0;
              data_d     = '0;
            end
          end
        end
        default: resp_d = DmiRespFailed;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      op_q       <= DmiNop;
      wdata_q    <= '0;
      resp_q     <= '0;
      rdata_q    <= '0;
      data_q     <= '0;
      dmactive_q <= 1'b0;
      ndmreset_q <= 1'b0;
      haltreq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      wdata_q    <= wdata_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
      data_q     <= data_d;
      dmactive_q <= dmactive_d;
      ndmreset_q <= ndmreset_d;
      haltreq_q  <= haltreq_d;
    end
  end

  assign debug_req_ready      = (state_q == StIdle) && !reset;
  assign debug_resp_valid     = (state_q == StResp);
  assign debug_resp_bits_resp = resp_q;
  assign debug_resp_bits_data = rdata_q;
  assign dmactive             = dmactive_q;
  assign ndmreset             = ndmreset_q;
  assign haltreq              = haltreq_q;

endmodule

// File: tb/tb_dmi_responder.sv
// Scoreboard bench for dmi_responder: WAIT_CYCLES=2 instance for the main flows,
// WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_dmi_responder;

  localparam int unsigned Wait = 2;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [6:0]  req_addr;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic        resp_valid, resp_ready;
  logic [1:0]  resp_resp;
  logic [31:0] resp_data;
  logic        dmactive, ndmreset, haltreq;

  logic        z_req_valid, z_req_ready;
  logic        z_resp_valid;
  logic [1:0]  z_resp_resp;
  logic [31:0] z_resp_data;
  logic        z_dmactive, z_ndmreset, z_haltreq;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  logic [31:0] m_data[4];
  logic        m_act, m_ndm, m_halt;

  always #5 clk = ~clk;

  dmi_responder #(.WAIT_CYCLES(Wait)) u_dut (
    .clk                 (clk),
    .reset               (reset),
    .debug_req_valid     (req_valid),
    .debug_req_ready     (req_ready),
    .debug_req_bits_addr (req_addr),
    .debug_req_bits_op   (req_op),
    .debug_req_bits_data (req_data),
    .debug_resp_valid    (resp_valid),
    .debug_resp_ready    (resp_ready),
    .debug_resp_bits_resp(resp_resp),
    .debug_resp_bits_data(resp_data),
    .dmactive            (dmactive),
    .ndmreset            (ndmreset),
    .haltreq             (haltreq)
  );

  dmi_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk                 (clk),
    .reset               (reset),
    .debug_req_valid     (z_req_valid),
    .debug_req_ready     (z_req_ready),
    .debug_req_bits_addr (7'h11),
    .debug_req_bits_op   (2'd1),
    .debug_req_bits_data (32'h0),
    .debug_resp_valid    (z_resp_valid),
    .debug_resp_ready    (1'b1),
    .debug_resp_bits_resp(z_resp_resp),
    .debug_resp_bits_data(z_resp_data),
    .dmactive            (z_dmactive),
    .ndmreset            (z_ndmreset),
    .haltreq             (z_haltreq)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_data[i] = '0;
    m_act  = 1'b0;
    m_ndm  = 1'b0;
    m_halt = 1'b0;
  endtask

  task automatic model_access(input logic [1:0] op, input logic [6:0] addr,
                              input logic [31:0] wd, output exp_t e);
    int idx;
    idx    = int'(addr) - 4;
    e.resp = 2'd0;
    e.data = 32'h0;
    if (op == 2'd3) begin
      e.resp = 2'd2;
    end else if (op == 2'd1) begin
      if (idx >= 0 && idx < 4) e.data = m_data[idx];
      else if (addr == 7'h10)  e.data = {m_halt, 29'd0, m_ndm, m_act};
      else if (addr == 7'h11)  e.data = 32'h0000_0082;
    end else if (op == 2'd2) begin
      if (idx >= 0 && idx < 4) begin
        m_data[idx] = wd;
      end else if (addr == 7'h10) begin
        if (wd[0]) begin
          m_act  = 1'b1;
          m_ndm  = wd[1];
          m_halt = wd[31];
        end else begin
          model_reset();
        end
      end
    end
  endtask

  // Issue one request, score the response, optionally stall resp_ready for hold cycles.
  task automatic xact(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                      input int hold);
    exp_t        e, got;
    int          n, lat;
    logic [1:0]  r0;
    logic [31:0] d0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = wd;
    model_access(op, addr, wd, e);
    sb_q.push_back(e);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check_eq("accept", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      void'(sb_q.pop_front());
      return;
    end
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      if (lat == 0) req_valid = 1'b0;
      lat++;
    end while (!resp_valid && lat < 20);
    check_eq("latency", 32'(lat), 32'(Wait + 1));
    if (!resp_valid) return;
    got = sb_q.pop_front();
    check_eq("resp", {30'd0, resp_resp}, {30'd0, got.resp});
    check_eq("rdata", resp_data, got.data);
    r0 = resp_resp;
    d0 = resp_data;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check_eq("hold_valid", {31'd0, resp_valid}, 32'd1);
      check_eq("hold_bits", {resp_resp, resp_data[29:0]}, {r0, d0[29:0]});
      check_eq("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check_eq("post_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("post_ready", {31'd0, req_ready}, 32'd1);
    check_eq("dmctl_out", {29'd0, haltreq, ndmreset, dmactive}, {29'd0, m_halt, m_ndm, m_act});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int hi;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_op      = '0;
    req_data    = '0;
    resp_ready  = 1'b0;
    z_req_valid = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("rst_outs", {haltreq, ndmreset, dmactive, resp_resp, resp_data[26:0]}, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("rel_req_ready", {31'd0, req_ready}, 32'd1);

    // dmcontrol set/readback, then a clearing write wipes scratch too
    xact(2'd2, 7'h10, 32'h8000_0003, 0);
    xact(2'd1, 7'h10, 32'h0, 0);
    xact(2'd2, 7'h06, 32'hDEAD_BEEF, 0);
    xact(2'd1, 7'h06, 32'h0, 0);
    xact(2'd2, 7'h10, 32'h8000_0000, 0);
    xact(2'd1, 7'h06, 32'h0, 0);

    // reserved op, dmstatus, unmapped, nop, write to read-only
    xact(2'd3, 7'h04, 32'h5555_5555, 0);
    xact(2'd1, 7'h11, 32'h0, 0);
    xact(2'd1, 7'h7F, 32'h0, 0);
    xact(2'd0, 7'h05, 32'hFFFF_FFFF, 0);
    xact(2'd2, 7'h11, 32'hFFFF_FFFF, 0);
    xact(2'd2, 7'h07, 32'hA5A5_0F0F, 0);
    xact(2'd1, 7'h07, 32'h0, 5);

    // Reset in the middle of a write's wait phase
    xact(2'd2, 7'h10, 32'h0000_0001, 0);
    xact(2'd1, 7'h11, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'd2;
    req_addr  = 7'h04;
    req_data  = 32'h0000_1234;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    check_eq("mid_rst_data", resp_data, 32'd0);
    check_eq("mid_rst_outs", {29'd0, haltreq, ndmreset, dmactive}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("post_rst_ready", {31'd0, req_ready}, 32'd1);
    hi = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (resp_valid) hi++;
    end
    check_eq("no_stale_resp", 32'(hi), 32'd0);
    xact(2'd1, 7'h04, 32'h0, 0);

    // Zero-wait instance: continuous reads alternate accept / respond
    @(negedge clk);
    z_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check_eq("z_valid", {31'd0, z_resp_valid}, {31'd0, (i % 2) == 0});
      check_eq("z_ready", {31'd0, z_req_ready}, {31'd0, (i % 2) != 0});
      if (z_resp_valid) check_eq("z_data", z_resp_data, 32'h0000_0082);
    end
    z_req_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
